// File: rtl/pixel_arb_pkg.sv
// Shared constants and the write-FIFO entry type for the pixel SRAM write arbiter.
package pixel_arb_pkg;

  // Framebuffer geometry (320x240 bytes) and raster timing origin.
  localparam int FB_WORDS = 76800;
  localparam int HSTART   = 159;  // last blanking h_count before active video
  localparam int VSTART   = 44;   // last blanking v_count before active video
  localparam int ACTIVE_W = 640;
  localparam int ACTIVE_H = 480;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  // One queued CPU write: byte address plus RRRGGGBB pixel.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/pixel_write_fifo.sv
// Synchronous write FIFO with registered level and ready. The head is popped
// only when the arbiter grants the SRAM to the CPU side.
module pixel_write_fifo
  import pixel_arb_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  wr_entry_t       din_i,
  input  logic            pop_en_i,
  output wr_entry_t       head_o,
  output logic            empty_o,
  output logic            pop_o,
  output logic            ready_o,
  output logic [LW-1:0]   level_o
);

  wr_entry_t         mem [DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              ready_q, ready_d;
  logic              push_ok;

  assign empty_o = (level_q == '0);
  assign pop_o   = pop_en_i && !empty_o;
  // A full FIFO refuses even when a pop happens in the same cycle.
  assign push_ok = push_i && ready_q;
  assign head_o  = mem[rptr_q];
  assign ready_o = ready_q;
  assign level_o = level_q;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_o)      level_d = level_q + 1'b1;
    else if (!push_ok && pop_o) level_d = level_q - 1'b1;
    ready_d = (level_d != LW'(DEPTH));
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_o)   rptr_q <= rptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= ready_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr_q] <= din_i;
  end

endmodule

// File: rtl/pixel_sram_write_arbiter.sv
// Shares the single-port framebuffer SRAM between the pixel engine's reads
// and queued CPU pixel writes. CPU writes drain only on cycles where the
// pixel engine does not sample SRAM data.
// Optional feature: define PIXEL_ARB_CLIP_EN to drop out-of-range CPU writes
// and flag them on the sticky clip_err output.
module pixel_sram_write_arbiter #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int FB_WORDS   = pixel_arb_pkg::FB_WORDS,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clkPixel,
  input  logic          reset,
  input  logic [11:0]   h_count,
  input  logic [11:0]   v_count,
  input  logic          halfRes,
  input  logic [16:0]   gpu_addr,
  input  logic          cpu_valid,
  output logic          cpu_ready,
  input  logic [16:0]   cpu_addr,
  input  logic [7:0]    cpu_data,
  output logic [16:0]   sram_addr,
  output logic [7:0]    sram_wdata,
  output logic          sram_we,
  output logic [LW-1:0] fifo_level,
  output logic          clip_err
);

`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic [11:0]              pa, la;
  logic                     active, fl, fp, gpu_slot;
  logic                     accept, clip_hit, enq, pop;
  logic                     clip_err_q;
  pixel_arb_pkg::wr_entry_t din, head;
  logic                     empty;

  // Slot decode: the pixel engine samples SRAM on the first pixel of each
  // scaled pixel group, on the first line of each scaled line group.
  always_comb begin
    pa       = h_count - 12'd160;
    la       = v_count - 12'd45;
    active   = (h_count > 12'(pixel_arb_pkg::HSTART)) &&
               (v_count > 12'(pixel_arb_pkg::VSTART)) &&
               (pa < 12'(pixel_arb_pkg::ACTIVE_W)) &&
               (la < 12'(pixel_arb_pkg::ACTIVE_H));
    fl       = halfRes ? (la[1:0] == 2'b00) : !la[0];
    fp       = halfRes ? (pa[1:0] == 2'b00) : !pa[0];
    gpu_slot = active && fl && fp;
  end

  // Out-of-range writes still complete the handshake but never reach the FIFO.
  always_comb begin
    accept   = cpu_valid && cpu_ready;
    clip_hit = CLIP_EN && ({15'd0, cpu_addr} >= 32'(FB_WORDS));
    enq      = accept && !clip_hit;
    din.addr = cpu_addr;
    din.data = cpu_data;
  end

  pixel_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clkPixel),
    .rst_i    (reset),
    .push_i   (enq),
    .din_i    (din),
    .pop_en_i (!gpu_slot),
    .head_o   (head),
    .empty_o  (empty),
    .pop_o    (pop),
    .ready_o  (cpu_ready),
    .level_o  (fifo_level)
  );

  // SRAM port mux: the FIFO head owns the port whenever it is popping,
  // otherwise the pixel engine's address passes straight through.
  always_comb begin
    sram_we    = pop;
    sram_addr  = pop ? head.addr : gpu_addr;
    sram_wdata = pop ? head.data : 8'h00;
  end

  // Sticky clip flag; stays clear forever when clipping is compiled out.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset)                  clip_err_q <= 1'b0;
    else if (accept && clip_hit) clip_err_q <= 1'b1;
  end

  assign clip_err = clip_err_q;

endmodule

// File: tb/tb_pixel_sram_write_arbiter.sv
// Directed bench for pixel_sram_write_arbiter with a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_pixel_sram_write_arbiter;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic          clkPixel = 1'b0;
  logic          reset;
  logic [11:0]   h_count, v_count;
  logic          halfRes;
  logic [16:0]   gpu_addr;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [16:0]   cpu_addr;
  logic [7:0]    cpu_data;
  logic [16:0]   sram_addr;
  logic [7:0]    sram_wdata;
  logic          sram_we;
  logic [LW-1:0] fifo_level;
  logic          clip_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit h_auto  = 1'b0;

  always #5 clkPixel = ~clkPixel;

  pixel_sram_write_arbiter #(.FIFO_DEPTH(DEPTH), .FB_WORDS(76800)) dut (
    .clkPixel   (clkPixel),
    .reset      (reset),
    .h_count    (h_count),
    .v_count    (v_count),
    .halfRes    (halfRes),
    .gpu_addr   (gpu_addr),
    .cpu_valid  (cpu_valid),
    .cpu_ready  (cpu_ready),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_we    (sram_we),
    .fifo_level (fifo_level),
    .clip_err   (clip_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: raster arithmetic straight from the timing description.
  function automatic bit slot_of(input int h, input int v, input bit hr);
    int x, y;
    x = h - 160;
    y = v - 45;
    if (x < 0 || x >= 640 || y < 0 || y >= 480) return 1'b0;
    if (hr) return (x % 4 == 0) && (y % 4 == 0);
    return (x % 2 == 0) && (y % 2 == 0);
  endfunction

  typedef struct { logic [16:0] a; logic [7:0] d; } ent_t;
  ent_t mq[$];
  bit   m_ready = 1'b1;
  bit   m_clip  = 1'b0;

  // Model: an ordered queue of pending writes; head leaves on any free cycle.
  always @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_ready <= 1'b1;
      m_clip  <= 1'b0;
    end else begin
      if (!slot_of(int'(h_count), int'(v_count), halfRes) && mq.size() > 0)
        void'(mq.pop_front());
      if (cpu_valid && m_ready) begin
        if (CLIP && int'(cpu_addr) >= 76800) m_clip <= 1'b1;
        else mq.push_back('{a: cpu_addr, d: cpu_data});
      end
      m_ready <= (mq.size() != DEPTH);
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clkPixel) begin
    if (!slot_of(int'(h_count), int'(v_count), halfRes) && mq.size() > 0) begin
      chk("m_we",    32'(sram_we),    32'd1);
      chk("m_addr",  32'(sram_addr),  32'(mq[0].a));
      chk("m_wdata", 32'(sram_wdata), 32'(mq[0].d));
    end else begin
      chk("m_we",    32'(sram_we),   32'd0);
      chk("m_addr",  32'(sram_addr), 32'(gpu_addr));
    end
    chk("m_level", 32'(fifo_level), 32'(mq.size()));
    chk("m_ready", 32'(cpu_ready),  32'(m_ready));
    chk("m_clip",  32'(clip_err),   32'(m_clip));
  end

  task automatic tick();
    @(posedge clkPixel);
    #1;
    if (h_auto) h_count = h_count + 12'd1;
    #1;
  endtask

  task automatic push(input logic [16:0] a, input logic [7:0] d);
    int n;
    cpu_addr  = a;
    cpu_data  = d;
    cpu_valid = 1'b1;
    n = 0;
    while (cpu_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got ready=%0b, expected ready=1 within 200 cycles", cpu_ready);
    end
    tick();
    cpu_valid = 1'b0;
    #1;
  endtask

  initial begin
    int expw[7];
    expw = '{1, 1, 1, 0, 1, 1, 1};
    reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_data = '0;
    h_count = 12'd0; v_count = 12'd10; halfRes = 1'b0; gpu_addr = 17'h1ABCD;
    repeat (3) @(posedge clkPixel);
    #1 reset = 1'b0;
    #1;
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ready", 32'(cpu_ready),  32'd1);
    chk("rst_we",    32'(sram_we),    32'd0);
    chk("rst_addr",  32'(sram_addr),  32'h1ABCD);
    chk("rst_clip",  32'(clip_err),   32'd0);

    // Vertical blanking: write lands the cycle after the accept edge.
    push(17'h00123, 8'hE3);
    chk("vb_we",    32'(sram_we),    32'd1);
    chk("vb_addr",  32'(sram_addr),  32'h00123);
    chk("vb_wdata", 32'(sram_wdata), 32'hE3);
    tick();
    chk("vb_drained", 32'(fifo_level), 32'd0);

    // First active line: h=160 belongs to the pixel engine, write lands at 161.
    v_count = 12'd45; h_count = 12'd159; h_auto = 1'b1;
    push(17'h0AAAA, 8'h5A);
    chk("l45_h", 32'(h_count), 32'd160);
    chk("l45_we160",   32'(sram_we),    32'd0);
    chk("l45_addr160", 32'(sram_addr),  32'h1ABCD);
    chk("l45_level",   32'(fifo_level), 32'd1);
    tick();
    chk("l45_we161",   32'(sram_we),   32'd1);
    chk("l45_addr161", 32'(sram_addr), 32'h0AAAA);
    tick();
    // Odd line is never blocked.
    v_count = 12'd46; h_count = 12'd159;
    push(17'h0BBBB, 8'hA5);
    chk("l46_we160",   32'(sram_we),   32'd1);
    chk("l46_addr160", 32'(sram_addr), 32'h0BBBB);
    tick();

    // Fill to 16 while parked on a GPU slot, then 17th stalls and drains.
    v_count = 12'd45; h_count = 12'd200; h_auto = 1'b0;
    for (int i = 0; i < 16; i++) push(17'h00100 + 17'(i), 8'(i + 1));
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ready", 32'(cpu_ready),  32'd0);
    h_auto = 1'b1;
    push(17'h00110, 8'h77);
    repeat (40) tick();
    chk("fill_drained", 32'(fifo_level), 32'd0);

    // Half resolution: engine owns only every fourth pixel of the first line.
    halfRes = 1'b1; v_count = 12'd45; h_count = 12'd160; h_auto = 1'b0;
    for (int i = 0; i < 6; i++) push(17'h00200 + 17'(i), 8'h40 + 8'(i));
    chk("hr_we160", 32'(sram_we), 32'd0);
    h_auto = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("hr_we%0d", 161 + k), 32'(sram_we), 32'(expw[k]));
    end
    tick();
    chk("hr_drained", 32'(fifo_level), 32'd0);
    halfRes = 1'b0;

    // Reset in the middle of a queued burst.
    h_count = 12'd200; h_auto = 1'b0;
    for (int i = 0; i < 5; i++) push(17'h00300 + 17'(i), 8'h90 + 8'(i));
    h_count = 12'd201;
    #1;
    chk("pre_rst_we", 32'(sram_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",    32'(sram_we),    32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    repeat (2) @(posedge clkPixel);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    chk("post_rst_ready", 32'(cpu_ready),  32'd1);

    // Framebuffer bound.
    v_count = 12'd10; h_count = 12'd0;
    push(17'd76800, 8'h55);
`ifdef PIXEL_ARB_CLIP_EN
    chk("clip_level", 32'(fifo_level), 32'd0);
    chk("clip_err",   32'(clip_err),   32'd1);
    chk("clip_we",    32'(sram_we),    32'd0);
    push(17'd76799, 8'h1C);
    chk("inb_we",   32'(sram_we),   32'd1);
    chk("inb_addr", 32'(sram_addr), 32'd76799);
    chk("clip_sticky", 32'(clip_err), 32'd1);
`else
    chk("noclip_we",   32'(sram_we),   32'd1);
    chk("noclip_addr", 32'(sram_addr), 32'd76800);
    chk("noclip_err",  32'(clip_err),  32'd0);
`endif
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
